// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I opcode constants, immediate-format enumeration and opcode helpers.
package cpu_pkg;
  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_REG      = 7'h33;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_IMM || op == OP_JALR) ? FMT_I :
           (op == OP_STORE)                                 ? FMT_S :
           (op == OP_BRANCH)                                ? FMT_B :
           (op == OP_LUI || op == OP_AUIPC)                 ? FMT_U :
           (op == OP_JAL)                                   ? FMT_J : FMT_NONE;
  endfunction

  function automatic logic rv32i_op(input logic [6:0] op);
    return op inside {OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
                      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational sign-extended immediate extraction selected by opcode format.
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0] INST,
  output logic [31:0] IMM
);
  imm_fmt_e fmt;
  assign fmt = imm_fmt(INST[6:0]);
  always_comb
    IMM = fmt == FMT_I ? {{20{INST[31]}}, INST[31:20]} :
          fmt == FMT_S ? {{20{INST[31]}}, INST[31:25], INST[11:7]} :
          fmt == FMT_B ? {{19{INST[31]}}, INST[31], INST[7], INST[30:25], INST[11:8], 1'b0} :
          fmt == FMT_U ? {INST[31:12], 12'b0} :
          fmt == FMT_J ? {{11{INST[31]}}, INST[31], INST[19:12], INST[20], INST[30:21], 1'b0} :
          32'b0;
endmodule

// File: rtl/inst_decode.sv
// inst_decode: RV32I decode stage with skid buffer and registered decode output.
// Define ID_ILLEGAL_CHECK_EN to build the unsupported-opcode check on ID_ILLEGAL.
module inst_decode
  import cpu_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_INST,
  input  logic        IF_INST_VALID,
  output logic        IF_STALL,
  input  logic        DN_STALL,
  input  logic        FLUSH,
  output logic        ID_VALID,
  output logic [31:0] ID_PC,
  output logic [6:0]  ID_OPCODE,
  output logic [2:0]  ID_FUNCT3,
  output logic [6:0]  ID_FUNCT7,
  output logic [4:0]  ID_RD,
  output logic [4:0]  ID_RS1,
  output logic [4:0]  ID_RS2,
  output logic [31:0] ID_IMM,
  output logic        ID_ILLEGAL,
  output logic        OVERFLOW
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          empty, full, deq, bypass, enq_req, enq, drop, load;
  logic [31:0]   src_pc, src_inst, src_imm;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // A dequeue frees the head slot in the same cycle, so a full buffer still accepts then.
  always_comb begin
    empty   = cnt == '0;
    full    = cnt == CW'(BUF_DEPTH);
    deq     = !DN_STALL && !empty;
    bypass  = !DN_STALL && empty && IF_INST_VALID;
    enq_req = IF_INST_VALID && !bypass;
    enq     = enq_req && (!full || deq);
    drop    = enq_req && full && !deq;
    load    = deq || bypass;
    cnt_nxt = cnt + CW'(enq) - CW'(deq);
    src_pc   = empty ? IF_PC : buf_pc[rd_ptr];
    src_inst = empty ? IF_INST : buf_inst[rd_ptr];
  end

  imm_gen u_imm_gen (.INST(src_inst), .IMM(src_imm));

  always_ff @(posedge CLK)
    if (!RST && !FLUSH && enq) begin
      buf_pc[wr_ptr]   <= IF_PC;
      buf_inst[wr_ptr] <= IF_INST;
    end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      IF_STALL  <= 1'b0;
      OVERFLOW  <= 1'b0;
      ID_VALID  <= 1'b0;
      ID_PC     <= '0;
      ID_OPCODE <= '0;
      ID_FUNCT3 <= '0;
      ID_FUNCT7 <= '0;
      ID_RD     <= '0;
      ID_RS1    <= '0;
      ID_RS2    <= '0;
      ID_IMM    <= '0;
    end else if (FLUSH) begin
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      IF_STALL <= 1'b0;
      ID_VALID <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      IF_STALL <= cnt_nxt != '0;
      if (enq) wr_ptr <= inc(wr_ptr);
      if (deq) rd_ptr <= inc(rd_ptr);
      if (drop) OVERFLOW <= 1'b1;
      if (!DN_STALL) ID_VALID <= load;
      if (load) begin
        ID_PC     <= src_pc;
        ID_OPCODE <= src_inst[6:0];
        ID_RD     <= src_inst[11:7];
        ID_FUNCT3 <= src_inst[14:12];
        ID_RS1    <= src_inst[19:15];
        ID_RS2    <= src_inst[24:20];
        ID_FUNCT7 <= src_inst[31:25];
        ID_IMM    <= src_imm;
      end
    end
  end

`ifdef ID_ILLEGAL_CHECK_EN
  always_ff @(posedge CLK)
    if (RST) ID_ILLEGAL <= 1'b0;
    else if (!FLUSH && load) ID_ILLEGAL <= src_inst[1:0] != 2'b11 || !rv32i_op(src_inst[6:0]);
`else
  assign ID_ILLEGAL = 1'b0;
`endif
endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode: scoreboard bench for inst_decode with directed, hand-decoded vectors.
module tb_inst_decode;
`ifdef ID_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } dec_t;
  typedef struct packed {
    logic [31:0] inst;
    dec_t        d;
  } vec_t;

  logic        CLK, RST, IF_INST_VALID, IF_STALL, DN_STALL, FLUSH;
  logic        ID_VALID, ID_ILLEGAL, OVERFLOW;
  logic [31:0] IF_PC, IF_INST, ID_PC, ID_IMM;
  logic [6:0]  ID_OPCODE, ID_FUNCT7;
  logic [2:0]  ID_FUNCT3;
  logic [4:0]  ID_RD, ID_RS1, ID_RS2;

  vec_t        vt [9];
  logic [96:0] sb [$];
  int          n_chk = 0, n_pass = 0;

  inst_decode #(.BUF_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .IF_PC(IF_PC), .IF_INST(IF_INST), .IF_INST_VALID(IF_INST_VALID),
    .IF_STALL(IF_STALL), .DN_STALL(DN_STALL), .FLUSH(FLUSH), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_OPCODE(ID_OPCODE), .ID_FUNCT3(ID_FUNCT3), .ID_FUNCT7(ID_FUNCT7), .ID_RD(ID_RD),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_IMM(ID_IMM), .ID_ILLEGAL(ID_ILLEGAL), .OVERFLOW(OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input int vi, input logic st,
                     input logic fl, input logic push);
    IF_INST_VALID = v;
    IF_PC = pc;
    IF_INST = vt[vi].inst;
    DN_STALL = st;
    FLUSH = fl;
    if (push) sb.push_back({pc, vt[vi].d});
    @(posedge CLK);
    #1;
    IF_INST_VALID = 1'b0;
    FLUSH = 1'b0;
  endtask

  // An output is consumed in any cycle where it is valid and downstream is not stalling.
  always @(negedge CLK)
    if (!RST && ID_VALID && !DN_STALL) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got pc %0h expected no output", ID_PC);
      end else
        chk("decode_out", {ID_PC, ID_OPCODE, ID_RD, ID_RS1, ID_RS2, ID_FUNCT3, ID_FUNCT7, ID_IMM, ID_ILLEGAL},
            sb.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = {32'h00500093, 7'h13, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 1'b0};
    vt[1] = {32'hFE000EE3, 7'h63, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0};
    vt[2] = {32'h123452B7, 7'h37, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0};
    vt[3] = {32'h00112623, 7'h23, 5'd12, 5'd2,  5'd1,  3'd2, 7'h00, 32'h0000000C, 1'b0};
    vt[4] = {32'h0080006F, 7'h6F, 5'd0,  5'd0,  5'd8,  3'd0, 7'h00, 32'h00000008, 1'b0};
    vt[5] = {32'h00000000, 7'h00, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, ILL_EN};
    vt[6] = {32'hFFC12083, 7'h03, 5'd1,  5'd2,  5'd28, 3'd2, 7'h7F, 32'hFFFFFFFC, 1'b0};
    vt[7] = {32'h0000000B, 7'h0B, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, ILL_EN};
    vt[8] = {32'hFFFFF117, 7'h17, 5'd2,  5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFFF000, 1'b0};
    RST = 1'b1;
    IF_INST_VALID = 1'b0;
    IF_PC = '0;
    IF_INST = '0;
    DN_STALL = 1'b0;
    FLUSH = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", ID_VALID, 0);
    chk("rst_if_stall", IF_STALL, 0);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_illegal", ID_ILLEGAL, 0);
    chk("rst_fields", {ID_PC, ID_OPCODE, ID_RD, ID_RS1, ID_RS2, ID_FUNCT3, ID_FUNCT7, ID_IMM}, 0);
    RST = 1'b0;

    cyc(1, 32'h100, 0, 0, 0, 1);
    chk("lat1_valid", ID_VALID, 1);
    chk("lat1_opcode", ID_OPCODE, 7'h13);
    chk("lat1_rd", ID_RD, 1);
    chk("lat1_imm", ID_IMM, 5);
    for (int i = 1; i < 9; i++) cyc(1, 32'h200 + 32'(4 * i), i, 0, 0, 1);
    chk("stream_no_stall", IF_STALL, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stream_drained", ID_VALID, 0);

    cyc(1, 32'h20000000, 0, 0, 0, 1);
    cyc(1, 32'h20000004, 1, 1, 0, 1);
    chk("hold_pc_1", ID_PC, 32'h20000000);
    cyc(1, 32'h20000008, 2, 1, 0, 1);
    chk("hold_pc_2", ID_PC, 32'h20000000);
    cyc(0, 0, 0, 1, 0, 0);
    chk("hold_pc_3", ID_PC, 32'h20000000);
    chk("hold_valid", ID_VALID, 1);
    chk("hold_if_stall", IF_STALL, 1);
    chk("hold_overflow", OVERFLOW, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("drain_if_stall", IF_STALL, 0);
    chk("drain_valid", ID_VALID, 0);

    cyc(1, 32'h500, 3, 0, 0, 1);
    cyc(1, 32'h504, 4, 1, 0, 1);
    cyc(1, 32'h508, 6, 0, 0, 1);
    chk("enqdeq_if_stall", IF_STALL, 1);
    chk("enqdeq_pc", ID_PC, 32'h504);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    chk("enqdeq_drained", ID_VALID, 0);

    cyc(1, 32'h300, 0, 0, 0, 0);
    cyc(1, 32'h304, 1, 1, 0, 0);
    cyc(1, 32'h308, 2, 1, 0, 0);
    chk("full_overflow", OVERFLOW, 0);
    chk("full_if_stall", IF_STALL, 1);
    cyc(1, 32'h30C, 3, 1, 0, 0);
    chk("drop_overflow", OVERFLOW, 1);
    chk("drop_pc", ID_PC, 32'h300);
    cyc(1, 32'h310, 4, 1, 1, 0);
    chk("flush_valid", ID_VALID, 0);
    chk("flush_if_stall", IF_STALL, 0);
    chk("flush_overflow_sticky", OVERFLOW, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("flush_no_emit", ID_VALID, 0);
    end
    cyc(1, 32'h600, 2, 0, 0, 1);
    chk("post_flush_lat1", {ID_VALID, ID_PC}, {1'b1, 32'h600});
    chk("post_flush_overflow", OVERFLOW, 1);
    cyc(0, 0, 0, 0, 0, 0);

    cyc(1, 32'h700, 0, 0, 0, 0);
    cyc(1, 32'h704, 1, 1, 0, 0);
    cyc(1, 32'h708, 2, 1, 0, 0);
    cyc(1, 32'h70C, 3, 1, 0, 0);
    RST = 1'b1;
    cyc(1, 32'h710, 4, 1, 1, 0);
    chk("midrst_valid", ID_VALID, 0);
    chk("midrst_if_stall", IF_STALL, 0);
    chk("midrst_overflow", OVERFLOW, 0);
    chk("midrst_illegal", ID_ILLEGAL, 0);
    chk("midrst_fields", {ID_PC, ID_OPCODE, ID_RD, ID_RS1, ID_RS2, ID_FUNCT3, ID_FUNCT7, ID_IMM}, 0);
    RST = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("midrst_no_emit", ID_VALID, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
